// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//   N-channel debouncer for active-low push-buttons (pin low = pressed).
//   Each channel has a 2-flop synchroniser, a 4-state debounce FSM and a
//   stability counter. It produces a debounced level plus one-cycle press and
//   release pulses per channel. It sits between the board key pins and the
//   snake direction/control logic.
//
//   Optional feature: define KEY_REPEAT_EN to add per-channel auto-repeat.
//   While a key stays in HELD, extra key_press pulses are generated
//   REPEAT_DELAY cycles after entering HELD, then every REPEAT_PERIOD cycles.
//   The port list is identical in both builds.
//
// Parameters
//   NUM_KEYS       number of independent channels (>=1)
//   DEBOUNCE_CYC   stable cycles required per edge (>=2)
//   REPEAT_DELAY   held cycles before the first auto-repeat (KEY_REPEAT_EN)
//   REPEAT_PERIOD  cycles between later auto-repeats (KEY_REPEAT_EN)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_in       in   raw asynchronous key pins, 0 = pressed
//   key_level    out  debounced level, 1 = pressed (registered)
//   key_press    out  one-cycle pulse per accepted press / repeat (registered)
//   key_release  out  one-cycle pulse per accepted release (registered)
//   any_press    out  combinational OR of key_press
// -----------------------------------------------------------------------------
module key_debounce_multi #(
    parameter int NUM_KEYS      = 4,
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    // Parameter sanity: the reload scheme for auto-repeat needs
    // REPEAT_DELAY >= REPEAT_PERIOD >= 1.
    localparam bit CFG_OK = (NUM_KEYS >= 1) && (DEBOUNCE_CYC >= 2) &&
                            (REPEAT_PERIOD >= 1) && (REPEAT_DELAY >= REPEAT_PERIOD);

    if (!CFG_OK) begin : g_bad_cfg
        $error("key_debounce_multi: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        logic          sync1_r;
        logic          sync2_r;
        logic          key_s;
        state_t        state_r;
        state_t        state_nxt_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          level_r;
        logic          level_nxt_s;
        logic          press_r;
        logic          press_fsm_s;
        logic          press_nxt_s;
        logic          release_r;
        logic          release_nxt_s;
        logic          rpt_hit_s;

        // Two-flop synchroniser; resets to the released level (1).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_r <= 1'b1;
                sync2_r <= 1'b1;
            end else begin
                sync1_r <= key_in[g];
                sync2_r <= sync1_r;
            end
        end

        assign key_s = sync2_r;

        // FSM, counter and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r   <= IDLE;
                cnt_r     <= {CW{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                state_r   <= state_nxt_s;
                cnt_r     <= cnt_nxt_s;
                level_r   <= level_nxt_s;
                press_r   <= press_nxt_s;
                release_r <= release_nxt_s;
            end
        end

        // Next-state logic and pulse generation for the debounce FSM.
        always_comb begin
            state_nxt_s   = state_r;
            level_nxt_s   = level_r;
            press_fsm_s   = 1'b0;
            release_nxt_s = 1'b0;
            case (state_r)
                IDLE: begin
                    if (key_s == 1'b0) begin
                        state_nxt_s = PRESS_WAIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s == 1'b1) begin
                        state_nxt_s = IDLE;
                    end else if (cnt_r == CNT_MAX) begin
                        state_nxt_s = HELD;
                        level_nxt_s = 1'b1;
                        press_fsm_s = 1'b1;
                    end else begin
                        state_nxt_s = PRESS_WAIT;
                    end
                end
                HELD: begin
                    if (key_s == 1'b1) begin
                        state_nxt_s = RELEASE_WAIT;
                    end else begin
                        state_nxt_s = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_s == 1'b0) begin
                        state_nxt_s = HELD;
                    end else if (cnt_r == CNT_MAX) begin
                        state_nxt_s   = IDLE;
                        level_nxt_s   = 1'b0;
                        release_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = RELEASE_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    level_nxt_s = 1'b0;
                end
            endcase
        end

        // Stability counter: cleared on any transition, saturating at CNT_MAX.
        always_comb begin
            if (state_nxt_s != state_r) begin
                cnt_nxt_s = {CW{1'b0}};
            end else if (cnt_r < CNT_MAX) begin
                cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end

`ifdef KEY_REPEAT_EN
        localparam int RW = $clog2(REPEAT_DELAY + 1);
        localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

        logic [RW-1:0] rcnt_r;
        logic [RW-1:0] rcnt_nxt_s;

        // Repeat counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt_r <= {RW{1'b0}};
            end else begin
                rcnt_r <= rcnt_nxt_s;
            end
        end

        // Repeat pulse fires only while staying in HELD. After a pulse the
        // counter reloads so the next hit lands REPEAT_PERIOD cycles later.
        always_comb begin
            rpt_hit_s = 1'b0;
            if ((state_r != HELD) || (state_nxt_s != HELD)) begin
                rcnt_nxt_s = {RW{1'b0}};
            end else if (rcnt_r == RPT_FIRST) begin
                rpt_hit_s  = 1'b1;
                rcnt_nxt_s = RPT_RELOAD;
            end else begin
                rcnt_nxt_s = rcnt_r + {{(RW-1){1'b0}}, 1'b1};
            end
        end
`else
        assign rpt_hit_s = 1'b0;
`endif

        assign press_nxt_s    = press_fsm_s | rpt_hit_s;
        assign key_level[g]   = level_r;
        assign key_press[g]   = press_r;
        assign key_release[g] = release_r;
    end

    assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
//   Self-checking bench for key_debounce_multi (NUM_KEYS=4, DEBOUNCE_CYC=8,
//   REPEAT_DELAY=40, REPEAT_PERIOD=10). A reference model describes each
//   channel as "key_in seen two edges late; flip the level after DB+1
//   consecutive disagreeing samples; repeat at age RD, RD+RP, ... while held".
//   Directed scenarios are followed by randomized key activity with
//   occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int RD = 40;
    localparam int RP = 10;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_press;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    key_debounce_multi #(
        .NUM_KEYS      (NK),
        .DEBOUNCE_CYC  (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .any_press   (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NK-1:0] hist1, hist2;
    logic [NK-1:0] m_level, m_press, m_release;
    int            m_run [NK];
    int            m_age [NK];

    // Behavioural model of all channels, stepped on the same clock as the DUT.
    always @(posedge clk or negedge rst_n) begin : ref_model
        logic [NK-1:0] lv, pr, rl;
        int            run_v, age_v;
        logic          pressed;
        if (!rst_n) begin
            hist1     <= '1;
            hist2     <= '1;
            m_level   <= '0;
            m_press   <= '0;
            m_release <= '0;
            for (int i = 0; i < NK; i++) begin
                m_run[i] <= 0;
                m_age[i] <= 0;
            end
        end else begin
            lv = m_level;
            pr = '0;
            rl = '0;
            for (int i = 0; i < NK; i++) begin
                pressed = ~hist2[i];
                run_v   = m_run[i];
                age_v   = m_age[i];
                if (pressed != lv[i]) begin
                    run_v = run_v + 1;
                    age_v = 0;
                    if (run_v == DB + 1) begin
                        lv[i] = pressed;
                        if (pressed) pr[i] = 1'b1;
                        else         rl[i] = 1'b1;
                        run_v = 0;
                    end
                end else begin
                    if (lv[i] && run_v == 0) begin
                        age_v = age_v + 1;
`ifdef KEY_REPEAT_EN
                        if (age_v >= RD && ((age_v - RD) % RP) == 0) pr[i] = 1'b1;
`endif
                    end else begin
                        age_v = 0;
                    end
                    run_v = 0;
                end
                m_run[i] <= run_v;
                m_age[i] <= age_v;
            end
            m_level   <= lv;
            m_press   <= pr;
            m_release <= rl;
            hist2     <= hist1;
            hist1     <= key_in;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("level",   {28'd0, key_level},   {28'd0, m_level});
            check("press",   {28'd0, key_press},   {28'd0, m_press});
            check("release", {28'd0, key_release}, {28'd0, m_release});
            check("any",     {31'd0, any_press},   {31'd0, |m_press});
        end
    end

    // Count rising edges until a channel's level matches want (bounded).
    task automatic edges_until_level(input int ch, input logic want, output int n);
        n = 99;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (key_level[ch] == want) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset asynchronously a little after a rising edge and check
    // that every output clears without waiting for a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_lvl"}, {28'd0, key_level},   32'd0);
        check({tag, "_prs"}, {28'd0, key_press},   32'd0);
        check({tag, "_rel"}, {28'd0, key_release}, 32'd0);
        check({tag, "_any"}, {31'd0, any_press},   32'd0);
        @(negedge clk);
    endtask

    int lat;
    int pcount;
    int exp_rep;
    int dur [NK];

    // Watchdog: the run is short, so this only trips on a hang.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        rst_n  = 1'b0;
        key_in = 4'hF;
        wait_neg(3);
        check("rst_lvl", {28'd0, key_level},   32'd0);
        check("rst_prs", {28'd0, key_press},   32'd0);
        check("rst_rel", {28'd0, key_release}, 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_neg(3);

        // 1. Press on channel 0: level and pulse on edge DB+3.
        key_in[0] = 1'b0;
        edges_until_level(0, 1'b1, lat);
        check("press_lat0", lat, DB + 3);
        check("press0_pulse", {28'd0, key_press}, 32'h1);
        @(posedge clk); #1;
        check("press0_width", {31'd0, key_press[0]}, 32'd0);
        @(negedge clk);
        wait_neg(5);

        // 2. Bounce on channel 1 never gets accepted.
        key_in[1] = 1'b0; wait_neg(5);
        key_in[1] = 1'b1; wait_neg(2);
        key_in[1] = 1'b0; wait_neg(5);
        key_in[1] = 1'b1; wait_neg(20);
        check("bounce_lvl1", {31'd0, key_level[1]}, 32'd0);

        // 3. Release channel 0, then a 3-cycle release glitch after re-press.
        key_in[0] = 1'b1;
        edges_until_level(0, 1'b0, lat);
        check("release_lat0", lat, DB + 3);
        check("release0_pulse", {28'd0, key_release}, 32'h1);
        @(posedge clk); #1;
        check("release0_width", {31'd0, key_release[0]}, 32'd0);
        @(negedge clk);
        key_in[0] = 1'b0; wait_neg(15);
        key_in[0] = 1'b1; wait_neg(3);
        key_in[0] = 1'b0; wait_neg(20);
        check("glitch_lvl0", {31'd0, key_level[0]}, 32'd1);

        // 4. Channels 2 and 3 pressed on the same edge.
        key_in[3:2] = 2'b00;
        edges_until_level(2, 1'b1, lat);
        check("simul_lat", lat, DB + 3);
        check("simul_press", {30'd0, key_press[3:2]}, 32'h3);
        check("simul_any", {31'd0, any_press}, 32'd1);
        @(negedge clk);

        // 5. Reset mid-PRESS_WAIT and mid-HELD; key held through reset.
        key_in = 4'hF; wait_neg(20);
        key_in[1] = 1'b0; wait_neg(5);
        async_reset("rst_pw");
        rst_n = 1'b1;
        key_in = 4'hF; wait_neg(5);
        key_in[0] = 1'b0; wait_neg(20);
        check("held_before_rst", {31'd0, key_level[0]}, 32'd1);
        async_reset("rst_held");
        wait_neg(2);
        rst_n = 1'b1;
        edges_until_level(0, 1'b1, lat);
        check("post_rst_lat", lat, DB + 3);

        // 6. Hold channel 0 for 100 cycles after the press edge.
        pcount = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (key_press[0]) pcount++;
        end
`ifdef KEY_REPEAT_EN
        exp_rep = (100 - RD) / RP + 1;
`else
        exp_rep = 0;
`endif
        check("repeat_count", pcount, exp_rep);
        @(negedge clk);
        key_in = 4'hF;
        wait_neg(20);

        // Randomized activity: mix of short bounces and long holds.
        for (int i = 0; i < NK; i++) dur[i] = $urandom_range(1, 20);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (dur[i] == 0) begin
                    key_in[i] = ~key_in[i];
                    if ($urandom_range(0, 3) == 0) dur[i] = $urandom_range(30, 90);
                    else                           dur[i] = $urandom_range(1, 14);
                end else begin
                    dur[i] = dur[i] - 1;
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rnd_rst");
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
